// File: rtl/uart_msg_receiver.sv
// UART receiver (8N1, LSB first) that assembles 2**MSG_LOG_WIDTH bytes into one
// message and hands it to a consumer through a valid/ack register.
module uart_msg_receiver #(
  parameter int CLK_CYCLES    = 4167,
  parameter int CTR_WIDTH     = 16,
  parameter int MSG_LOG_WIDTH = 3,
  parameter int TIMEOUT_BITS  = 20
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                uart_rx,
  output logic [8*(2**MSG_LOG_WIDTH)-1:0]     data,
  output logic                                valid,
  input  logic                                ack,
  output logic                                frame_err,
  output logic                                overrun
);

  localparam int unsigned MSG_BITS  = 8 * (2 ** MSG_LOG_WIDTH);
  localparam int unsigned TO_CYCLES = TIMEOUT_BITS * CLK_CYCLES;
  localparam int unsigned TO_WIDTH  = $clog2(TO_CYCLES + 1);

  localparam logic [CTR_WIDTH-1:0] HALF_LOAD = CTR_WIDTH'(CLK_CYCLES / 2 - 1);
  localparam logic [CTR_WIDTH-1:0] FULL_LOAD = CTR_WIDTH'(CLK_CYCLES - 1);
  localparam logic [TO_WIDTH-1:0]  TO_LAST   = TO_WIDTH'(TO_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t                     state;
  logic                       rx_meta;
  logic                       rxs;
  logic [CTR_WIDTH-1:0]       timer;
  logic [2:0]                 bit_cnt;
  logic [7:0]                 shift;
  logic [MSG_LOG_WIDTH-1:0]   idx;
  logic [MSG_BITS-1:0]        buffer;
  logic [TO_WIDTH-1:0]        idle_cnt;
  logic                       msg_done;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      timer     <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      idx       <= '0;
      buffer    <= '0;
      idle_cnt  <= '0;
      msg_done  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      msg_done  <= 1'b0;

      // Partial-message timeout only runs while idle with bytes pending.
      if (state == IDLE && idx != '0) begin
        if (idle_cnt == TO_LAST) begin
          idx      <= '0;
          idle_cnt <= '0;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end else begin
        idle_cnt <= '0;
      end

      case (state)
        IDLE: begin
          if (!rxs) begin
            timer <= HALF_LOAD;
            state <= START;
          end
        end
        START: begin
          if (timer != '0) begin
            timer <= timer - 1'b1;
          end else if (rxs) begin
            state <= IDLE;
          end else begin
            timer   <= FULL_LOAD;
            bit_cnt <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (timer != '0) begin
            timer <= timer - 1'b1;
          end else begin
            shift <= {rxs, shift[7:1]};
            timer <= FULL_LOAD;
            if (bit_cnt == 3'd7) begin
              state <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        STOP: begin
          if (timer != '0) begin
            timer <= timer - 1'b1;
          end else if (rxs) begin
            buffer[{idx, 3'b000} +: 8] <= shift;
            idx      <= idx + 1'b1;
            msg_done <= (idx == '1);
            state    <= IDLE;
          end else begin
            frame_err <= 1'b1;
            idx       <= '0;
            state     <= WAIT_HIGH;
          end
        end
        WAIT_HIGH: begin
          if (rxs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handoff register: a completed message wins over a same-cycle ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data    <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else if (msg_done) begin
      if (!valid || ack) begin
        data  <= buffer;
        valid <= 1'b1;
      end else begin
        overrun <= 1'b1;
      end
    end else if (ack && valid) begin
      valid   <= 1'b0;
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_msg_receiver.sv
// Scoreboard bench for uart_msg_receiver with 16 clocks/bit and 2-byte messages.
module tb_uart_msg_receiver;

  localparam int CLK_CYCLES    = 16;
  localparam int CTR_WIDTH     = 8;
  localparam int MSG_LOG_WIDTH = 1;
  localparam int TIMEOUT_BITS  = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        uart_rx = 1'b1;
  logic [15:0] data;
  logic        valid;
  logic        ack = 1'b0;
  logic        frame_err;
  logic        overrun;

  int vectors = 0;
  int miscompares = 0;
  int fe_count = 0;
  logic [15:0] expq[$];
  logic        prev_valid = 1'b0;
  logic [15:0] prev_data = '0;

  uart_msg_receiver #(
    .CLK_CYCLES   (CLK_CYCLES),
    .CTR_WIDTH    (CTR_WIDTH),
    .MSG_LOG_WIDTH(MSG_LOG_WIDTH),
    .TIMEOUT_BITS (TIMEOUT_BITS)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .uart_rx  (uart_rx),
    .data     (data),
    .valid    (valid),
    .ack      (ack),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  // Monitor: every new message presented (valid rise or data change while valid).
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid <= valid;
      prev_data  <= data;
    end else begin
      if (frame_err) fe_count++;
      if (valid && (!prev_valid || data != prev_data)) begin
        vectors++;
        if (expq.size() == 0) begin
          miscompares++;
          $display("FAIL msg_unexpected: got data=%h, none expected", data);
        end else begin
          logic [15:0] e;
          e = expq.pop_front();
          if (data !== e) begin
            miscompares++;
            $display("FAIL msg_data: got %h, expected %h", data, e);
          end
        end
      end
      prev_valid <= valid;
      prev_data  <= data;
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic v);
    uart_rx = v;
    repeat (CLK_CYCLES) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop_ok);
    if (!stop_ok) send_bit(1'b1);
    send_bit(1'b1);
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!valid) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: valid=0, expected 1 within 400 clocks", name);
    end
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_data", data, 16'h0000);
    check("rst_valid", {15'd0, valid}, 16'd0);
    check("rst_frame_err", {15'd0, frame_err}, 16'd0);
    check("rst_overrun", {15'd0, overrun}, 16'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Basic two-byte message
    expq.push_back(16'h1234);
    send_byte(8'h34, 1'b1);
    send_byte(8'h12, 1'b1);
    wait_valid("basic");
    check("basic_frame_err_cnt", 16'(fe_count), 16'd0);
    pulse_ack();

    // Short low glitch must not start a byte
    uart_rx = 1'b0;
    repeat (4) @(negedge clk);
    uart_rx = 1'b1;
    repeat (3 * CLK_CYCLES) @(negedge clk);
    check("glitch_valid", {15'd0, valid}, 16'd0);
    check("glitch_frame_err_cnt", 16'(fe_count), 16'd0);

    // Framing error discards byte and restarts the message
    expq.push_back(16'hBBAA);
    send_byte(8'h55, 1'b0);
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    wait_valid("frame");
    check("frame_err_cnt", 16'(fe_count), 16'd1);
    pulse_ack();

    // Second message dropped while first unconsumed
    expq.push_back(16'h1111);
    send_byte(8'h11, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h22, 1'b1);
    check("ovr_data", data, 16'h1111);
    check("ovr_overrun", {15'd0, overrun}, 16'd1);
    pulse_ack();
    check("ovr_ack_valid", {15'd0, valid}, 16'd0);
    check("ovr_ack_overrun", {15'd0, overrun}, 16'd0);

    // Stale partial byte discarded by idle timeout
    expq.push_back(16'h0201);
    send_byte(8'h99, 1'b1);
    repeat (6 * CLK_CYCLES) @(negedge clk);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    wait_valid("timeout");

    // Asynchronous reset during bit 3 of byte 0 (message left unacked)
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    uart_rx = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_data", data, 16'h0000);
    check("arst_valid", {15'd0, valid}, 16'd0);
    check("arst_frame_err", {15'd0, frame_err}, 16'd0);
    check("arst_overrun", {15'd0, overrun}, 16'd0);
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    expq.push_back(16'h0C0D);
    send_byte(8'h0D, 1'b1);
    send_byte(8'h0C, 1'b1);
    wait_valid("post_reset");
    repeat (4) @(negedge clk);

    check("queue_drained", 16'(expq.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
